// File: rtl/fcc_duty_controller.sv
// fcc_duty_controller: sampled integral voltage loop with flying-cap balance.
// Optional balance term enabled by defining FC_BALANCE_EN.
module fcc_duty_controller #(
  parameter int ADC_W    = 12,
  parameter int D_NOM    = 64,
  parameter int D_MIN    = 5,
  parameter int D_MAX    = 122,
  parameter int KI_SHIFT = 4,
  parameter int KB_SHIFT = 3,
  parameter int DB_MAX   = 16
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             XADC_Event,
  input  logic             enable,
  input  logic [ADC_W-1:0] vref,
  input  logic [ADC_W-1:0] fc_ref,
  output logic             sample_req,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_vout,
  input  logic [ADC_W-1:0] adc_vfc,
  output logic [6:0]       d1,
  output logic [6:0]       d2,
  output logic             duty_valid,
  output logic             overrun
);

  localparam int AW = ADC_W + KI_SHIFT + 3;

  localparam logic signed [AW-1:0] ACC_LO =
    AW'((D_MIN - D_NOM) * (2 ** KI_SHIFT));
  localparam logic signed [AW-1:0] ACC_HI =
    AW'((D_MAX - D_NOM) * (2 ** KI_SHIFT));
  localparam logic signed [AW-1:0] DNOM_S = AW'(D_NOM);
  localparam logic signed [AW-1:0] DMIN_S = AW'(D_MIN);
  localparam logic signed [AW-1:0] DMAX_S = AW'(D_MAX);
  localparam logic [6:0]           DNOM7  = 7'(D_NOM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_CALC,
    S_APPLY
  } state_e;

  function automatic logic [6:0] clamp_duty(
    input logic signed [AW-1:0] x
  );
    logic signed [AW-1:0] y;
    y = x;
    if (x < DMIN_S) y = DMIN_S;
    if (x > DMAX_S) y = DMAX_S;
    return 7'(y);
  endfunction

  state_e                state_q, state_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [ADC_W-1:0]      vout_q, vout_d;
  logic [6:0]            d1_q, d1_d;
  logic [6:0]            d2_q, d2_d;
  logic                  dv_q, dv_d;
  logic                  ovr_q, ovr_d;

  logic signed [ADC_W:0] e;
  logic signed [AW-1:0]  acc_sum;
  logic signed [AW-1:0]  dc;
  logic signed [AW-1:0]  d1_sum;
  logic signed [AW-1:0]  d2_sum;

`ifdef FC_BALANCE_EN
  localparam logic signed [AW-1:0] DB_HI = AW'(DB_MAX);
  localparam logic signed [AW-1:0] DB_LO = AW'(-DB_MAX);

  logic [ADC_W-1:0]      vfc_q, vfc_d;
  logic signed [AW-1:0]  db_q, db_d;
  logic signed [ADC_W:0] fc_err;
  logic signed [AW-1:0]  db_raw;
`else
  logic unused_fc;
  assign unused_fc = ^{fc_ref, adc_vfc};
`endif

  // Next-state, loop arithmetic and duty update
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    vout_d  = vout_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    dv_d    = 1'b0;
    ovr_d   = ovr_q | (XADC_Event & (state_q != S_IDLE));

    e = $signed({1'b0, vref}) - $signed({1'b0, vout_q});
    acc_sum = acc_q + AW'(e);
    dc = DNOM_S + (acc_q >>> KI_SHIFT);

`ifdef FC_BALANCE_EN
    vfc_d  = vfc_q;
    db_d   = db_q;
    fc_err = $signed({1'b0, fc_ref}) - $signed({1'b0, vfc_q});
    db_raw = AW'(fc_err >>> KB_SHIFT);
    d1_sum = dc + db_q;
    d2_sum = dc - db_q;
`else
    d1_sum = dc;
    d2_sum = dc;
`endif

    if (!enable) begin
      state_d = S_IDLE;
      acc_d   = '0;
      d1_d    = DNOM7;
      d2_d    = DNOM7;
      dv_d    = (d1_q != DNOM7) | (d2_q != DNOM7);
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (XADC_Event) state_d = S_REQ;
        end
        S_REQ: begin
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (adc_valid) begin
            vout_d  = adc_vout;
`ifdef FC_BALANCE_EN
            vfc_d   = adc_vfc;
`endif
            state_d = S_CALC;
          end
        end
        S_CALC: begin
          acc_d = acc_sum;
          if (acc_sum < ACC_LO) acc_d = ACC_LO;
          if (acc_sum > ACC_HI) acc_d = ACC_HI;
`ifdef FC_BALANCE_EN
          db_d = db_raw;
          if (db_raw < DB_LO) db_d = DB_LO;
          if (db_raw > DB_HI) db_d = DB_HI;
`endif
          state_d = S_APPLY;
        end
        S_APPLY: begin
          d1_d    = clamp_duty(d1_sum);
          d2_d    = clamp_duty(d2_sum);
          dv_d    = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      vout_q  <= '0;
      d1_q    <= DNOM7;
      d2_q    <= DNOM7;
      dv_q    <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef FC_BALANCE_EN
      vfc_q   <= '0;
      db_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      vout_q  <= vout_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      dv_q    <= dv_d;
      ovr_q   <= ovr_d;
`ifdef FC_BALANCE_EN
      vfc_q   <= vfc_d;
      db_q    <= db_d;
`endif
    end
  end

  assign sample_req = (state_q == S_REQ);
  assign d1         = d1_q;
  assign d2         = d2_q;
  assign duty_valid = dv_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_fcc_duty_controller.sv
// Directed bench for fcc_duty_controller.
// Expectations follow FC_BALANCE_EN when it is defined.
module tb_fcc_duty_controller;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        XADC_Event = 1'b0;
  logic        enable = 1'b0;
  logic [11:0] vref = 12'd2000;
  logic [11:0] fc_ref = 12'd1000;
  logic        sample_req;
  logic        adc_valid = 1'b0;
  logic [11:0] adc_vout = '0;
  logic [11:0] adc_vfc = '0;
  logic [6:0]  d1;
  logic [6:0]  d2;
  logic        duty_valid;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  int dv_cnt = 0;

  fcc_duty_controller dut (
    .clk        (clk),
    .RST        (RST),
    .XADC_Event (XADC_Event),
    .enable     (enable),
    .vref       (vref),
    .fc_ref     (fc_ref),
    .sample_req (sample_req),
    .adc_valid  (adc_valid),
    .adc_vout   (adc_vout),
    .adc_vfc    (adc_vfc),
    .d1         (d1),
    .d2         (d2),
    .duty_valid (duty_valid),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sample_req) req_cnt <= req_cnt + 1;
    if (duty_valid) dv_cnt <= dv_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_sample(
    input string       tag,
    input logic [11:0] vo,
    input logic [11:0] vf,
    input int          e1,
    input int          e2
  );
    XADC_Event = 1'b1;
    tick();
    XADC_Event = 1'b0;
    check({tag, "_req"}, 32'(sample_req), 1);
    tick();
    adc_valid = 1'b1;
    adc_vout  = vo;
    adc_vfc   = vf;
    tick();
    adc_valid = 1'b0;
    tick();
    check({tag, "_dv_early"}, 32'(duty_valid), 0);
    tick();
    check({tag, "_dv"}, 32'(duty_valid), 1);
    check({tag, "_d1"}, 32'(d1), 32'(e1));
    check({tag, "_d2"}, 32'(d2), 32'(e2));
  endtask

  int integ_exp[7] = '{74, 84, 94, 104, 114, 122, 122};
  int b1a, b2a, b1b, b2b;
  int snap;

  initial begin
`ifdef FC_BALANCE_EN
    b1a = 69; b2a = 59; b1b = 80; b2b = 48;
`else
    b1a = 64; b2a = 64; b1b = 64; b2b = 64;
`endif

    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    check("rst_d1", 32'(d1), 64);
    check("rst_d2", 32'(d2), 64);
    check("rst_req", 32'(sample_req), 0);
    check("rst_dv", 32'(duty_valid), 0);
    check("rst_ovr", 32'(overrun), 0);

    enable = 1'b1;
    vref   = 12'd2000;
    fc_ref = 12'd1000;
    tick();

    snap = dv_cnt;
    for (int i = 0; i < 10; i++) begin
      do_sample("steady", 12'd2000, 12'd1000, 64, 64);
    end
    tick();
    check("steady_dv_count", 32'(dv_cnt - snap), 10);

    for (int i = 0; i < 7; i++) begin
      do_sample($sformatf("integ%0d", i), 12'd1840, 12'd1000,
                integ_exp[i], integ_exp[i]);
    end
    do_sample("unwind", 12'd2160, 12'd1000, 112, 112);

    enable = 1'b0;
    tick();
    check("dis_d1", 32'(d1), 64);
    check("dis_d2", 32'(d2), 64);
    check("dis_dv", 32'(duty_valid), 1);
    enable = 1'b1;
    tick();
    check("dis_dv_once", 32'(duty_valid), 0);

    do_sample("bal_small", 12'd2000, 12'd960, b1a, b2a);
    do_sample("bal_clamp", 12'd2000, 12'd0, b1b, b2b);
    do_sample("bal_zero", 12'd2000, 12'd1000, 64, 64);

    do_sample("pre_abort", 12'd1840, 12'd1000, 74, 74);
    XADC_Event = 1'b1;
    tick();
    XADC_Event = 1'b0;
    tick();
    enable = 1'b0;
    tick();
    check("abort_d1", 32'(d1), 64);
    check("abort_d2", 32'(d2), 64);
    check("abort_dv", 32'(duty_valid), 1);
    enable    = 1'b1;
    adc_valid = 1'b1;
    adc_vout  = 12'd0;
    tick();
    adc_valid = 1'b0;
    snap = dv_cnt;
    repeat (5) tick();
    check("late_valid_dv", 32'(dv_cnt - snap), 0);
    check("late_valid_d1", 32'(d1), 64);
    check("abort_ovr", 32'(overrun), 0);
    do_sample("acc_cleared", 12'd2000, 12'd1000, 64, 64);

    snap = req_cnt;
    XADC_Event = 1'b1;
    tick();
    XADC_Event = 1'b0;
    repeat (49) tick();
    check("ovr_before", 32'(overrun), 0);
    XADC_Event = 1'b1;
    tick();
    XADC_Event = 1'b0;
    check("ovr_set", 32'(overrun), 1);
    repeat (5) tick();
    check("ovr_sticky", 32'(overrun), 1);
    check("ovr_one_req", 32'(req_cnt - snap), 1);

    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    check("rst2_ovr", 32'(overrun), 0);
    check("rst2_d1", 32'(d1), 64);

    vref = 12'd0;
    do_sample("sat_low", 12'd4095, 12'd1000, 5, 5);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/fcc_duty_controller.md
# fcc_duty_controller

Closed-loop duty-cycle generator for the 3-level flying-capacitor converter. Sits directly upstream of the phase-shifted PWM stage. Once per carrier period, on that stage's `XADC_Event` pulse, it requests an ADC sample of output and flying-capacitor voltage. It then runs an integral output-voltage loop plus a proportional capacitor-balance term, and drives the 7-bit `d1`/`d2` duty inputs of the PWM stage.

## Interface
Parameters:
- `ADC_W`, 12, ADC sample width (unsigned)
- `D_NOM`, 64, duty value after reset/disable
- `D_MIN`, 5, lower duty clamp
- `D_MAX`, 122, upper duty clamp
- `KI_SHIFT`, 4, integrator gain = 2^-KI_SHIFT duty LSB per ADC LSB
- `KB_SHIFT`, 3, balance gain = 2^-KB_SHIFT
- `DB_MAX`, 16, magnitude clamp of balance term

Ports:
- `clk` in 1: the one clock
- `RST` in 1: reset, synchronous and active-high
- `XADC_Event` in 1: one-cycle pulse per carrier period, from the triangle generator
- `enable` in 1: loop enable
- `vref` in ADC_W: output-voltage setpoint
- `fc_ref` in ADC_W: flying-capacitor setpoint
- `sample_req` out 1: one-cycle ADC conversion request
- `adc_valid` in 1: one-cycle pulse, samples valid
- `adc_vout` in ADC_W: output-voltage sample
- `adc_vfc` in ADC_W: flying-capacitor sample
- `d1` out 7: duty for phase 0
- `d2` out 7: duty for phase 180
- `duty_valid` out 1: one-cycle pulse when `d1`/`d2` change
- `overrun` out 1: sticky flag, cleared only by `RST`

## Operation
- FSM states:
  - IDLE: on `XADC_Event & enable`, go to REQ.
  - REQ: `sample_req`=1 for this cycle, then WAIT.
  - WAIT: on `adc_valid`, capture `adc_vout`/`adc_vfc` and go to CALC.
  - CALC: update accumulator, compute balance term, then APPLY.
  - APPLY: register `d1`/`d2`, then IDLE.
- `XADC_Event` in any state other than IDLE:
  - sets `overrun`
  - is otherwise ignored
  - no second request is issued
- `adc_valid` outside WAIT is ignored.
- Error: `e = vref - vout`, signed ADC_W+1 bits.
- Accumulator `acc`, signed:
  - Update: `acc = sat(acc + e)`.
  - Bounds: [(D_MIN-D_NOM)<<KI_SHIFT, (D_MAX-D_NOM)<<KI_SHIFT]. The clamp is the anti-windup.
  - Intermediate width must be at least ADC_W+KI_SHIFT+3 so nothing overflows before saturation.
- Common duty: `dc = D_NOM + (acc >>> KI_SHIFT)`. The shift is arithmetic (floor), so `dc` is always within [D_MIN, D_MAX].
- Balance term: `db = clamp((fc_ref - vfc) >>> KB_SHIFT, -DB_MAX, +DB_MAX)`.
- Outputs:
  - `d1 = clamp(dc + db, D_MIN, D_MAX)`
  - `d2 = clamp(dc - db, D_MIN, D_MAX)`
- `enable` low:
  - Next cycle: FSM to IDLE, abandoning any in-flight sample.
  - `acc` = 0.
  - `d1` = `d2` = D_NOM.
  - `duty_valid` pulses only if `d1` or `d2` changed.
- `RST` has priority over everything.

## Timing
- Reset values:
  - state IDLE
  - `acc` 0
  - `d1` = `d2` = D_NOM
  - `sample_req`, `duty_valid`, `overrun` all 0
- `XADC_Event` high in cycle T (FSM in IDLE): `sample_req` is high in cycle T+1.
- `adc_valid` high in cycle N (FSM in WAIT):
  - CALC at N+1
  - APPLY at N+2
  - new `d1`/`d2` visible and `duty_valid`=1 in cycle N+3
- `adc_valid` in the same cycle as `XADC_Event` while in WAIT: the sample is accepted and `overrun` is set.
- `duty_valid` pulses every APPLY, even if the values did not change.
- `d1`/`d2` are stable between updates; the PWM stage may consume them at any cycle.
- Minimum carrier period for no overrun: ADC latency + 4 cycles.

## Configuration
- Macro: `FC_BALANCE_EN`.
- Defined: balance term active as above.
- Undefined:
  - `db` ≡ 0, so `d1` = `d2` = `dc`.
  - `adc_vfc` and `fc_ref` are ignored; their capture registers are omitted.

## Test plan
Default parameters unless stated.
- Reset: assert `RST` for 2 cycles -> `d1`=`d2`=64; `sample_req`, `duty_valid`, `overrun` = 0.
- Steady state: `vref`=2000, `vout`=2000, `fc_ref`=`vfc`=1000, 10 events -> `d1`=`d2`=64; `duty_valid` pulses 10 times at `adc_valid`+3.
- Integrator step: `vref`=2000, `vout`=1840 (e=160), one sample -> `acc`=160, `d1`=`d2`=74. After a second identical sample -> 84. Repeated samples -> saturate at 122, and the first sample with `vout`=2160 afterwards drops the duty to 112, with no windup.
- Balance (macro on): e=0, `fc_ref`=1000, `vfc`=960 -> `d1`=69, `d2`=59. With `vfc`=0 -> `db` clamps at 16: `d1`=80, `d2`=48. Macro off -> both 64.
- Overrun: `XADC_Event` at T, no `adc_valid`, second `XADC_Event` at T+50 -> `overrun`=1 stays set; exactly one `sample_req`.
- Disable mid-operation: drop `enable` while in WAIT -> next cycle IDLE, `acc`=0, `d1`=`d2`=64; a late `adc_valid` is ignored.
